// File: rtl/ifetch_pcreg_if.sv
// Instruction-bus handshake between the fetch PC register and the instruction SRAM.
interface ifetch_pcreg_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iaddr_ok;
    logic        idata_ok;
    logic [31:0] idata;

    modport master (output ireq, output iaddr, input iaddr_ok, input idata_ok, input idata);
    modport slave  (input ireq, input iaddr, output iaddr_ok, output idata_ok, output idata);
endinterface

// File: rtl/ifetch_pcreg.sv
// Fetch PC register: issues one instruction-bus request per PC and presents pc/raw_instr to fetch.
//   state   | meaning
//   REQ     | issue address for pc (or present misaligned pc with raw_instr=0)
//   WAIT    | address accepted, awaiting data
//   HOLD    | data buffered while downstream is stalled
//   DISCARD | squashed request still outstanding, drop its data
module ifetch_pcreg #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           pc_next,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic                  stall,
    ifetch_pcreg_if.master        ibus,
    output logic [31:0]           pc,
    output logic [31:0]           raw_instr,
    output logic                  valid
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] buffer;
    logic        misaligned;
    logic        ireq_c;
    logic        data_valid;

    assign misaligned = (pc[1:0] != 2'b00);
    assign ireq_c     = resetn && (state == REQ) && !misaligned;
    assign data_valid = (state == WAIT) && ibus.idata_ok;

    assign ibus.ireq  = ireq_c;
    assign ibus.iaddr = pc;

    // Outputs are combinational so returned data reaches fetch in the response cycle.
    always_comb begin
        valid     = 1'b0;
        raw_instr = 32'h0;
        if (resetn && !redirect) begin
            case (state)
                REQ:     valid = misaligned;
                WAIT: begin
                    valid     = ibus.idata_ok;
                    raw_instr = ibus.idata_ok ? ibus.idata : 32'h0;
                end
                HOLD: begin
                    valid     = 1'b1;
                    raw_instr = buffer;
                end
                default: valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc     <= RESET_PC;
            state  <= REQ;
            buffer <= 32'h0;
        end else if (redirect) begin
            // An accepted address must be tracked to completion even when squashed.
            pc <= redirect_pc;
            case (state)
                REQ:     state <= (ireq_c && ibus.iaddr_ok) ? DISCARD : REQ;
                WAIT:    state <= ibus.idata_ok ? REQ : DISCARD;
                HOLD:    state <= REQ;
                DISCARD: state <= ibus.idata_ok ? REQ : DISCARD;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (misaligned) begin
                        if (!stall) pc <= pc_next;
                    end else if (ibus.iaddr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_valid) begin
                        if (stall) begin
                            buffer <= ibus.idata;
                            state  <= HOLD;
                        end else begin
                            pc    <= pc_next;
                            state <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc    <= pc_next;
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (ibus.idata_ok) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: doc/ifetch_pcreg.md
# ifetch_pcreg

Holds the architectural fetch PC and runs the instruction-bus request/response handshake for it. It sits directly upstream of the fetch stage: it receives the next sequential/branch PC from PC select, issues one instruction-SRAM request per PC, and presents the PC plus the returned instruction word to fetch with a valid flag. It also absorbs downstream stalls and pipeline redirects, including dropping responses to squashed in-flight requests.

## Interface
Parameters:
- RESET_PC, 32'hbfc0_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pc_next  in  32  next PC from PC select, taken when the current instruction retires into fetch.
- redirect  in  1  flush: abandon current PC/request, jump to redirect_pc.
- redirect_pc  in  32  redirect target.
- stall  in  1  fetch/decode register cannot accept an instruction this cycle.
- ireq  out  1  instruction-bus address request.
- iaddr  out  32  request address, always equal to pc.
- iaddr_ok  in  1  bus accepted the address this cycle.
- idata_ok  in  1  response data valid this cycle; never in the same cycle as the matching iaddr_ok.
- idata  in  32  response instruction word.
- pc  out  32  current fetch PC, to fetch stage.
- raw_instr  out  32  instruction word for pc, to fetch stage.
- valid  out  1  pc/raw_instr form a complete instruction this cycle.

## Operation
- States: REQ (issue address), WAIT (address accepted, awaiting data), HOLD (data buffered, downstream stalled), DISCARD (squashed request outstanding).
- At most one outstanding bus transaction.
- "Retire" = valid && !stall && !redirect: pc <= pc_next, state <= REQ.
- REQ, pc[1:0]==0: ireq=1, valid=0; iaddr_ok -> WAIT.
- REQ, pc[1:0]!=0: ireq=0, valid=1, raw_instr=0 (fetch flags the exception); no bus access; retires like a normal instruction.
- WAIT: ireq=0; idata_ok -> valid=1, raw_instr=idata (combinational pass-through); if stall, latch idata into buffer -> HOLD; else retire.
- HOLD: ireq=0, valid=1, raw_instr=buffer; on !stall retire.
- DISCARD: ireq=0, valid=0; idata_ok -> data dropped, -> REQ.
- Redirect, highest priority, any state: pc <= redirect_pc, valid forced 0 that cycle. Next state:
  - REQ with iaddr_ok -> DISCARD; otherwise REQ.
  - WAIT with idata_ok -> REQ; without -> DISCARD.
  - HOLD -> REQ.
  - DISCARD with idata_ok -> REQ; without -> DISCARD.
- ireq is not gated by redirect or stall; an accepted address is always tracked to completion.
- PC arithmetic is not performed here; pc_next/redirect_pc are taken verbatim (32-bit, wrap is upstream's concern).

## Timing
- Reset (resetn low, async): pc=RESET_PC, state=REQ, buffer=0; outputs valid=0, raw_instr=0, ireq=0 while resetn low, iaddr=RESET_PC. ireq rises combinationally once resetn is high.
- Reset mid-transaction discards all state; the instruction bus shares resetn, so no response from before reset is seen.
- Minimum latency per instruction: address accepted in cycle N, data_ok in N+1 with valid=1 that cycle, next request in N+2 (one instruction per 2 cycles at zero wait).
- Stall holds pc, raw_instr and valid stable every cycle until released; released cycle retires.
- Misaligned PC: valid in the same cycle the PC enters REQ.
- Redirect takes effect on the next edge; new ireq to redirect_pc the cycle after, unless DISCARD is pending.

## Test plan
- Reset release, bus grants iaddr_ok immediately, idata_ok next cycle with 32'h2402_0001, stall=0 -> ireq with iaddr=bfc00000, then valid=1 raw_instr=24020001 pc=bfc00000, then ireq with iaddr=pc_next=bfc00004.
- Stall=1 for 3 cycles over data_ok with idata=32'h1234_5678, bus drives idata=X afterwards -> HOLD, valid=1 and raw_instr=12345678 stable all 3 cycles; retire on release, no new ireq during stall.
- Redirect to 32'h8000_0180 in WAIT, idata_ok 2 cycles later with 32'hdead_beef -> DISCARD, valid=0 throughout, dead_beef never presented, next ireq iaddr=80000180.
- Redirect in same cycle as idata_ok -> valid=0, no DISCARD, next cycle ireq for redirect_pc.
- pc_next=32'hbfc0_0006 -> no ireq, valid=1 raw_instr=0 pc=bfc00006 immediately; retires to following pc_next.
- Assert resetn low while in WAIT -> outputs at reset values asynchronously, pc=bfc00000 after release.
